// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues sequential word fetches, buffers {word, pc} in a small ring
// and presents one instruction (or an FLI word pair) per decode handshake.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic [31:0] instr1,
    output logic [31:0] pc,
    output logic        is_pair
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [6:0] OpFli = 7'b1000100;
    localparam logic [CntW-1:0] CntDepth = CntW'(DEPTH);
    localparam logic [CntW-1:0] CntOne = CntW'(1);
    localparam logic [CntW-1:0] CntTwo = CntW'(2);

    logic [31:0]     word_q [DEPTH];
    logic [31:0]     wpc_q  [DEPTH];
    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d, head_nxt;
    logic [CntW-1:0] count_q, count_d, pop_n;
    logic [31:0]     fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
    logic            outstanding_q, outstanding_d, drop_q, drop_d;
    logic            push, fire, grant;
    logic            unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];
    assign head_nxt  = head_q + PtrW'(1);
    assign imem_req  = !rst && !redirect && !outstanding_q && (count_q < CntDepth);
    assign imem_addr = fetch_pc_q;
    assign grant     = imem_req && imem_gnt;
    // A response is dropped if it belongs to a flushed stream or lands with a redirect.
    assign push      = imem_rvalid && !drop_q && !redirect;
    assign fire      = out_valid && out_ready && !redirect;

    always_comb begin
        instr     = '0;
        instr1    = '0;
        pc        = '0;
        is_pair   = 1'b0;
        out_valid = 1'b0;
        if (count_q != '0) begin
            instr   = word_q[head_q];
            pc      = wpc_q[head_q];
            is_pair = (word_q[head_q][6:0] == OpFli);
            if (count_q >= CntTwo) begin
                instr1 = word_q[head_nxt];
            end
            out_valid = is_pair ? (count_q >= CntTwo) : 1'b1;
        end
    end

    always_comb begin
        pop_n         = fire ? (is_pair ? CntTwo : CntOne) : '0;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        if (redirect) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            if (imem_rvalid) begin
                outstanding_d = 1'b0;
                drop_d        = 1'b0;
            end else if (outstanding_q) begin
                drop_d = 1'b1;
            end
        end else begin
            head_d  = head_q + pop_n[PtrW-1:0];
            count_d = count_q + CntW'(push) - pop_n;
            if (push) begin
                tail_d = tail_q + PtrW'(1);
            end
            if (imem_rvalid) begin
                outstanding_d = 1'b0;
                drop_d        = 1'b0;
            end
            if (grant) begin
                outstanding_d = 1'b1;
                req_pc_d      = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= '0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // Storage needs no reset: outputs are gated by count.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            word_q[tail_q] <= imem_rdata;
            wpc_q[tail_q]  <= req_pc_q;
        end
    end

endmodule
